// File: rtl/devision_seq_param_if.sv
// Operand/result handshake bundle for the sequential divider.
// The producer/consumer side uses master; the divider uses slave.
interface devision_seq_param_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow, busy
  );
endinterface

// File: rtl/devision_seq_param.sv
// Multi-cycle restoring shift-subtract divider, STEPS_PER_CYCLE quotient bits per clock,
// signed/unsigned with divide-by-zero and MIN/-1 overflow flags.
module devision_seq_param #(
  parameter int WIDTH           = 16,
  parameter int STEPS_PER_CYCLE = 1,
  parameter bit SIGNED_EN       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  devision_seq_param_if.slave  bus
);
  localparam int N     = WIDTH / STEPS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, r_reg, dividend_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg, neg_r_reg, dz_pend_reg, ovf_pend_reg;
  logic             div_zero_reg, overflow_reg;
  logic             accept, sgn, sign_a, sign_b;

  assign accept = bus.in_valid && (state_reg == IDLE);
  assign sgn    = bus.is_signed && SIGNED_EN;
  assign sign_a = sgn && bus.dividend[WIDTH-1];
  assign sign_b = sgn && bus.divisor[WIDTH-1];

  // R is kept as WIDTH bits: after every step it is below B, only the shifted value needs WIDTH+1.
  logic [WIDTH-1:0] r_chain [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] a_chain [STEPS_PER_CYCLE+1];
  assign r_chain[0] = r_reg;
  assign a_chain[0] = a_reg;

  generate
    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
      logic [WIDTH:0]   r_sh;
      logic [WIDTH-1:0] r_diff;
      logic             ge;
      assign r_sh            = {r_chain[gi], a_chain[gi][WIDTH-1]};
      assign ge              = (r_sh >= {1'b0, b_reg});
      assign r_diff          = r_sh[WIDTH-1:0] - b_reg;
      assign r_chain[gi+1]   = ge ? r_diff : r_sh[WIDTH-1:0];
      assign a_chain[gi+1]   = {a_chain[gi][WIDTH-2:0], ge};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A zero divisor skips CALC entirely; FIX still registers its fixed result.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (bus.divisor == '0) ? FIX : CALC;
      CALC:    if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      r_reg         <= '0;
      dividend_reg  <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      cnt_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      dz_pend_reg   <= 1'b0;
      ovf_pend_reg  <= 1'b0;
      div_zero_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          a_reg        <= sign_a ? -bus.dividend : bus.dividend;
          b_reg        <= sign_b ? -bus.divisor : bus.divisor;
          r_reg        <= '0;
          cnt_reg      <= '0;
          dividend_reg <= bus.dividend;
          neg_q_reg    <= sign_a ^ sign_b;
          neg_r_reg    <= sign_a;
          dz_pend_reg  <= (bus.divisor == '0);
          ovf_pend_reg <= sgn && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
          div_zero_reg <= 1'b0;
          overflow_reg <= 1'b0;
        end
        CALC: begin
          a_reg   <= a_chain[STEPS_PER_CYCLE];
          r_reg   <= r_chain[STEPS_PER_CYCLE];
          cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
        FIX: begin
          // |MIN| / 1 already yields MIN with equal signs, so overflow only needs the flag.
          if (dz_pend_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= dividend_reg;
          end else begin
            quotient_reg  <= neg_q_reg ? -a_reg : a_reg;
            remainder_reg <= neg_r_reg ? -r_reg : r_reg;
          end
          div_zero_reg <= dz_pend_reg;
          overflow_reg <= ovf_pend_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.div_zero  = div_zero_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_devision_seq_param.sv
// Scoreboard bench: a 16/1 signed divider and a 16/4 unsigned-only divider, random and
// directed operands, expected results from plain integer arithmetic.
module tb_devision_seq_param;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst1_n, rst4_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  devision_seq_param_if #(.WIDTH(16)) bus1();
  devision_seq_param_if #(.WIDTH(16)) bus4();

  devision_seq_param #(.WIDTH(16), .STEPS_PER_CYCLE(1), .SIGNED_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1));
  devision_seq_param #(.WIDTH(16), .STEPS_PER_CYCLE(4), .SIGNED_EN(1'b0)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(bus4));

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Truncating integer division, with the divide-by-zero and MIN/-1 rules on top.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic sgn);
    exp_t e;
    int   sa, sb;
    e.dz = 1'b0; e.ov = 1'b0; e.lat = 0; e.acc = 0; e.hold = 0;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
    end else if (sgn) begin
      if (sa == -32768 && sb == -1) begin
        e.q = 16'h8000; e.r = 16'h0000; e.ov = 1'b1;
      end else begin
        e.q = 16'(sa / sb);
        e.r = 16'(sa % sb);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic issue1(logic [15:0] a, logic [15:0] b, logic s, int hold, bit track);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus1.in_ready && t < 300) begin @(negedge clk); t++; end
    if (!bus1.in_ready) begin bound_fail("d1_in_ready_wait"); return; end
    bus1.dividend = a; bus1.divisor = b; bus1.is_signed = s; bus1.in_valid = 1'b1;
    e = model(a, b, s);
    e.lat = (b == 16'd0) ? 1 : 17;
    e.acc = cyc + 1;
    e.hold = hold;
    if (track) q1.push_back(e);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.dividend = 16'($urandom); bus1.divisor = 16'($urandom); bus1.is_signed = 1'($urandom);
  endtask

  task automatic issue4(logic [15:0] a, logic [15:0] b, logic s);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus4.in_ready && t < 300) begin @(negedge clk); t++; end
    if (!bus4.in_ready) begin bound_fail("d4_in_ready_wait"); return; end
    bus4.dividend = a; bus4.divisor = b; bus4.is_signed = s; bus4.in_valid = 1'b1;
    e = model(a, b, 1'b0);
    e.lat = (b == 16'd0) ? 1 : 5;
    e.acc = cyc + 1;
    e.hold = 0;
    q4.push_back(e);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.dividend = 16'($urandom); bus4.divisor = 16'($urandom); bus4.is_signed = 1'($urandom);
  endtask

  task automatic rand_ops(output logic [15:0] a, output logic [15:0] b, output logic s);
    int sel;
    sel = $urandom_range(0, 9);
    a = 16'($urandom);
    b = 16'($urandom);
    s = 1'($urandom);
    if (sel == 0) b = 16'd0;
    else if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; end
    else if (sel == 2) b = 16'($urandom_range(1, 15));
  endtask

  // Monitor for the 16/1 divider: compares each new result and holds it under backpressure.
  initial begin
    exp_t cur;
    bit   seen;
    int   stall;
    seen = 1'b0; stall = 0;
    bus1.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1_n && bus1.out_valid) begin
        if (!seen) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL d1_unexpected_out actual=out_valid required=idle");
          end else begin
            cur = q1.pop_front();
            seen = 1'b1;
            check("d1_latency", cyc - cur.acc, cur.lat);
            stall = (cur.hold > 0) ? cur.hold : $urandom_range(0, 2);
          end
        end
        if (seen) begin
          check("d1_quotient", bus1.quotient, cur.q);
          check("d1_remainder", bus1.remainder, cur.r);
          check("d1_div_zero", bus1.div_zero, cur.dz);
          check("d1_overflow", bus1.overflow, cur.ov);
          check("d1_in_ready_done", bus1.in_ready, 0);
          check("d1_busy_done", bus1.busy, 1);
        end
        bus1.out_ready = (stall == 0);
        if (stall > 0) stall--;
        if (bus1.out_ready) seen = 1'b0;
      end else begin
        bus1.out_ready = 1'($urandom);
      end
    end
  end

  // Monitor for the 16/4 divider.
  initial begin
    exp_t cur;
    bit   seen;
    int   stall;
    seen = 1'b0; stall = 0;
    bus4.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst4_n && bus4.out_valid) begin
        if (!seen) begin
          if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL d4_unexpected_out actual=out_valid required=idle");
          end else begin
            cur = q4.pop_front();
            seen = 1'b1;
            check("d4_latency", cyc - cur.acc, cur.lat);
            stall = $urandom_range(0, 2);
          end
        end
        if (seen) begin
          check("d4_quotient", bus4.quotient, cur.q);
          check("d4_remainder", bus4.remainder, cur.r);
          check("d4_div_zero", bus4.div_zero, cur.dz);
          check("d4_overflow", bus4.overflow, cur.ov);
        end
        bus4.out_ready = (stall == 0);
        if (stall > 0) stall--;
        if (bus4.out_ready) seen = 1'b0;
      end else begin
        bus4.out_ready = 1'($urandom);
      end
    end
  end

  task automatic drain1();
    int t;
    t = 0;
    while ((q1.size() != 0 || bus1.out_valid) && t < 500) begin @(negedge clk); t++; end
    if (q1.size() != 0 || bus1.out_valid) bound_fail("d1_drain");
  endtask

  task automatic drain4();
    int t;
    t = 0;
    while ((q4.size() != 0 || bus4.out_valid) && t < 500) begin @(negedge clk); t++; end
    if (q4.size() != 0 || bus4.out_valid) bound_fail("d4_drain");
  endtask

  task automatic run1();
    logic [15:0] a, b;
    logic        s;
    int          nvalid;
    rst1_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.dividend = 16'd0; bus1.divisor = 16'd0; bus1.is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("d1_rst_in_ready", bus1.in_ready, 1);
    check("d1_rst_out_valid", bus1.out_valid, 0);
    check("d1_rst_busy", bus1.busy, 0);
    check("d1_rst_quotient", bus1.quotient, 0);
    rst1_n = 1'b1;

    issue1(16'd100, 16'd7, 1'b0, 5, 1'b1);
    issue1(16'hFFF9, 16'h0002, 1'b1, 0, 1'b1);
    issue1(16'hFFF9, 16'h0002, 1'b0, 0, 1'b1);
    issue1(16'd5, 16'd0, 1'b0, 0, 1'b1);
    issue1(16'hFFFF, 16'h0001, 1'b0, 0, 1'b1);
    issue1(16'h8000, 16'hFFFF, 1'b0, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      rand_ops(a, b, s);
      issue1(a, b, s, 0, 1'b1);
    end
    issue1(16'h8000, 16'hFFFF, 1'b1, 0, 1'b1);
    drain1();

    // Reset mid-calculation: the in-flight division must vanish without a result.
    issue1(16'd1234, 16'd5, 1'b0, 0, 1'b0);
    repeat (8) @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    check("d1_midrst_in_ready", bus1.in_ready, 1);
    check("d1_midrst_out_valid", bus1.out_valid, 0);
    check("d1_midrst_busy", bus1.busy, 0);
    check("d1_midrst_quotient", bus1.quotient, 0);
    check("d1_midrst_remainder", bus1.remainder, 0);
    check("d1_midrst_overflow", bus1.overflow, 0);
    check("d1_midrst_div_zero", bus1.div_zero, 0);
    @(negedge clk);
    rst1_n = 1'b1;
    nvalid = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus1.out_valid) nvalid++;
    end
    check("d1_midrst_no_result", nvalid, 0);
    issue1(16'd100, 16'd7, 1'b1, 0, 1'b1);
    drain1();
  endtask

  task automatic run4();
    logic [15:0] a, b;
    logic        s;
    rst4_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.dividend = 16'd0; bus4.divisor = 16'd0; bus4.is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("d4_rst_in_ready", bus4.in_ready, 1);
    check("d4_rst_out_valid", bus4.out_valid, 0);
    rst4_n = 1'b1;
    issue4(16'd1000, 16'd33, 1'b0);
    issue4(16'hFFF9, 16'h0002, 1'b1);
    issue4(16'h8000, 16'hFFFF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      rand_ops(a, b, s);
      issue4(a, b, s);
    end
    drain4();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      run1();
      run4();
    join
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
